// File: rtl/div_scheduler_if.sv
// Request, divider-handshake and result signals of the centroid divide scheduler.
// Latency: none, wires only.
// Backpressure: the divider paces the scheduler through div_ready; start is dropped while busy.
interface div_scheduler_if #(
    parameter int SUM_WIDTH = 32,
    parameter int X_WIDTH   = 10,
    parameter int Y_WIDTH   = 9
);
    logic                   start;
    logic [4*SUM_WIDTH-1:0] sum_x;
    logic [4*SUM_WIDTH-1:0] sum_y;
    logic [4*SUM_WIDTH-1:0] num;
    logic                   div_start;
    logic [SUM_WIDTH-1:0]   div_dividend;
    logic [SUM_WIDTH-1:0]   div_divisor;
    logic                   div_ready;
    logic [SUM_WIDTH-1:0]   div_quotient;
    logic [4*X_WIDTH-1:0]   avg_x;
    logic [4*Y_WIDTH-1:0]   avg_y;
    logic [3:0]             zero_mask;
    logic                   busy;
    logic                   done;

    // Scheduler side.
    modport master (
        input  start, sum_x, sum_y, num, div_ready, div_quotient,
        output div_start, div_dividend, div_divisor, avg_x, avg_y, zero_mask, busy, done
    );

    // Requester / divider side.
    modport slave (
        output start, sum_x, sum_y, num, div_ready, div_quotient,
        input  div_start, div_dividend, div_divisor, avg_x, avg_y, zero_mask, busy, done
    );
endinterface

// File: rtl/div_scheduler.sv
// Sequences eight sum/count divides (x and y for four colors) through one shared divider. Optional: DIV_SCHED_SMOOTH_EN.
// Latency: 8*(3+L)+2 cycles start-to-done counted inclusively, L = divider latency; a zero-count job costs 2 cycles.
// Backpressure: start is ignored while busy; each job waits as long as the divider holds div_ready low.
module div_scheduler #(
    parameter int SUM_WIDTH = 32,
    parameter int X_WIDTH   = 10,
    parameter int Y_WIDTH   = 9
) (
    input  logic            clk,
    input  logic            reset,
    div_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, STORE, FINISH} state_t;

    localparam logic [SUM_WIDTH-1:0] X_MAX = SUM_WIDTH'((64'd1 << X_WIDTH) - 64'd1);
    localparam logic [SUM_WIDTH-1:0] Y_MAX = SUM_WIDTH'((64'd1 << Y_WIDTH) - 64'd1);

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             job_k;
    logic [4*SUM_WIDTH-1:0] lat_sum_x;
    logic [4*SUM_WIDTH-1:0] lat_sum_y;
    logic [4*SUM_WIDTH-1:0] lat_num;
    logic [SUM_WIDTH-1:0]   quot_q;
    logic [4*X_WIDTH-1:0]   avg_x_q;
    logic [4*Y_WIDTH-1:0]   avg_y_q;
    logic [3:0]             zero_mask_q;

    logic [1:0]             job_color;
    logic                   job_axis;
    int                     base_s;
    int                     base_x;
    int                     base_y;
    logic [SUM_WIDTH-1:0]   op_dividend;
    logic [SUM_WIDTH-1:0]   op_divisor;
    logic                   op_zero;
    logic [X_WIDTH-1:0]     x_sat;
    logic [Y_WIDTH-1:0]     y_sat;
    logic [X_WIDTH-1:0]     x_new;
    logic [Y_WIDTH-1:0]     y_new;
    logic                   div_start_c;
    logic                   busy_c;
    logic                   done_c;

    // Job k carries color k>>1 and axis k[0] (0 = x, 1 = y).
    assign job_color = job_k[2:1];
    assign job_axis  = job_k[0];

    // Operands come straight from the latched snapshot, so they stay put while job_k holds.
    always_comb begin
        base_s      = int'(job_color) * SUM_WIDTH;
        op_divisor  = lat_num[base_s +: SUM_WIDTH];
        op_dividend = job_axis ? lat_sum_y[base_s +: SUM_WIDTH] : lat_sum_x[base_s +: SUM_WIDTH];
        op_zero     = (op_divisor == '0);
    end

    // Saturate the captured quotient to the field width, then optionally blend with the old value.
    always_comb begin
        base_x = int'(job_color) * X_WIDTH;
        base_y = int'(job_color) * Y_WIDTH;
        x_sat  = (quot_q > X_MAX) ? {X_WIDTH{1'b1}} : quot_q[X_WIDTH-1:0];
        y_sat  = (quot_q > Y_MAX) ? {Y_WIDTH{1'b1}} : quot_q[Y_WIDTH-1:0];
`ifdef DIV_SCHED_SMOOTH_EN
        x_new  = (x_sat >> 1) + (avg_x_q[base_x +: X_WIDTH] >> 1);
        y_new  = (y_sat >> 1) + (avg_y_q[base_y +: Y_WIDTH] >> 1);
`else
        x_new  = x_sat;
        y_new  = y_sat;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded outputs; ready is ignored in ARM because it is still the previous result's.
    always_comb begin
        state_nxt   = state;
        div_start_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        case (state)
            IDLE:   if (bus.start) state_nxt = ISSUE;
            ISSUE: begin
                busy_c      = 1'b1;
                div_start_c = !op_zero;
                state_nxt   = op_zero ? STORE : ARM;
            end
            ARM: begin
                busy_c    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy_c = 1'b1;
                if (bus.div_ready) state_nxt = STORE;
            end
            STORE: begin
                busy_c    = 1'b1;
                state_nxt = (job_k == 3'd7) ? FINISH : ISSUE;
            end
            FINISH: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot the inputs when a run is accepted; later input changes cannot disturb the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_sum_x <= '0;
            lat_sum_y <= '0;
            lat_num   <= '0;
        end else if (state == IDLE && bus.start) begin
            lat_sum_x <= bus.sum_x;
            lat_sum_y <= bus.sum_y;
            lat_num   <= bus.num;
        end
    end

    // Job index restarts at acceptance and advances once per STORE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             job_k <= '0;
        else if (state == IDLE && bus.start)    job_k <= '0;
        else if (state == STORE)                job_k <= job_k + 3'd1;
    end

    // Capture the quotient the moment the divider reports it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               quot_q <= '0;
        else if (state == WAIT && bus.div_ready)  quot_q <= bus.div_quotient;
    end

    // Write only the addressed field; a zero count leaves the field alone and flags the color.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg_x_q     <= '0;
            avg_y_q     <= '0;
            zero_mask_q <= '0;
        end else if (state == IDLE && bus.start) begin
            zero_mask_q <= '0;
        end else if (state == STORE) begin
            if (op_zero)       zero_mask_q[job_color]      <= 1'b1;
            else if (job_axis) avg_y_q[base_y +: Y_WIDTH] <= y_new;
            else               avg_x_q[base_x +: X_WIDTH] <= x_new;
        end
    end

    assign bus.div_start    = div_start_c;
    assign bus.div_dividend = op_dividend;
    assign bus.div_divisor  = op_divisor;
    assign bus.avg_x        = avg_x_q;
    assign bus.avg_y        = avg_y_q;
    assign bus.zero_mask    = zero_mask_q;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
endmodule

// File: tb/tb_div_scheduler.sv
// Randomized self-checking bench for div_scheduler against an arithmetic centroid model.
// Latency: divider model raises ready L cycles after sampling div_start, keeping the stale ready through ARM.
// Backpressure: start is pulsed only from the bench; mid-run pulses are expected to be dropped.
module tb_div_scheduler;
    localparam int SW = 32;
    localparam int XW = 10;
    localparam int YW = 9;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_scheduler_if #(.SUM_WIDTH(SW), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    div_scheduler #(.SUM_WIDTH(SW), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Divider model state.
    int             div_lat     = 33;
    int             start_count = 0;
    int             div_cnt     = 0;
    logic [SW-1:0]  pend_q;
    logic [SW-1:0]  seen_dividend;
    logic [SW-1:0]  seen_divisor;

    // Reference results.
    longint unsigned exp_x [4];
    longint unsigned exp_y [4];
    logic [3:0]      exp_zm;

    // Shared divider: ready stays high (stale) through the cycle after div_start, drops, then
    // returns with the quotient L cycles after the edge that sampled div_start.
    initial begin
        bus.div_ready    = 1'b1;
        bus.div_quotient = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                bus.div_ready = 1'b1;
                div_cnt       = 0;
            end else if (div_cnt > 0) begin
                checks++;
                if (bus.div_start !== 1'b0 || bus.div_dividend !== seen_dividend || bus.div_divisor !== seen_divisor) begin
                    failures++;
                    $display("FAIL div_hold: start=%0b dividend=%0d divisor=%0d required start=0 dividend=%0d divisor=%0d",
                             bus.div_start, bus.div_dividend, bus.div_divisor, seen_dividend, seen_divisor);
                end
                div_cnt--;
                if (div_cnt == 0) begin
                    bus.div_ready    = 1'b1;
                    bus.div_quotient = pend_q;
                end else if (div_cnt < div_lat) begin
                    bus.div_ready = 1'b0;
                end
            end else if (bus.div_start === 1'b1) begin
                start_count++;
                checks++;
                if (bus.div_divisor === '0) begin
                    failures++;
                    $display("FAIL div_zero_issue: divisor=%0d required nonzero", bus.div_divisor);
                end
                seen_dividend    = bus.div_dividend;
                seen_divisor     = bus.div_divisor;
                pend_q           = (bus.div_divisor != '0) ? bus.div_dividend / bus.div_divisor : '1;
                div_cnt          = div_lat + 1;
                bus.div_quotient = $urandom();
            end
        end
    end

    function automatic logic [4*SW-1:0] pack4(input longint unsigned a0, a1, a2, a3);
        logic [4*SW-1:0] r;
        r = {SW'(a3), SW'(a2), SW'(a1), SW'(a0)};
        return r;
    endfunction

    function automatic logic [4*XW-1:0] pack_x();
        logic [4*XW-1:0] r;
        for (int c = 0; c < 4; c++) r[c*XW +: XW] = exp_x[c][XW-1:0];
        return r;
    endfunction

    function automatic logic [4*YW-1:0] pack_y();
        logic [4*YW-1:0] r;
        for (int c = 0; c < 4; c++) r[c*YW +: YW] = exp_y[c][YW-1:0];
        return r;
    endfunction

    // Centroid model: per color, quotient of sum by count, clamped to the field maximum.
    // Cycle count is inclusive of the start cycle and the done cycle.
    task automatic model_run(input logic [4*SW-1:0] sx, sy, n, output int exp_cycles);
        longint unsigned nn, qx, qy, xmax, ymax;
        xmax       = (64'd1 << XW) - 1;
        ymax       = (64'd1 << YW) - 1;
        exp_cycles = 2;
        exp_zm     = '0;
        for (int c = 0; c < 4; c++) begin
            nn = n[c*SW +: SW];
            if (nn == 0) begin
                exp_zm[c]   = 1'b1;
                exp_cycles += 4;
            end else begin
                qx = sx[c*SW +: SW];
                qy = sy[c*SW +: SW];
                qx = qx / nn;
                qy = qy / nn;
                if (qx > xmax) qx = xmax;
                if (qy > ymax) qy = ymax;
`ifdef DIV_SCHED_SMOOTH_EN
                exp_x[c] = (qx >> 1) + (exp_x[c] >> 1);
                exp_y[c] = (qy >> 1) + (exp_y[c] >> 1);
`else
                exp_x[c] = qx;
                exp_y[c] = qy;
`endif
                exp_cycles += 2 * (div_lat + 3);
            end
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 4; c++) begin
            exp_x[c] = 0;
            exp_y[c] = 0;
        end
        exp_zm = '0;
    endtask

    // Drives one run; optionally re-pulses start and scrambles the inputs while the first job is waiting.
    task automatic run(input logic [4*SW-1:0] sx, sy, n, input bit disturb,
                       output int cycles, output bit done_seen, output bit busy_at_done,
                       output bit done_after, output bit busy_early);
        bus.sum_x   = sx;
        bus.sum_y   = sy;
        bus.num     = n;
        start_count = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        cycles    = 1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        cycles     = 2;
        busy_early = bus.busy;
        while (bus.done !== 1'b1 && cycles < 4000) begin
            @(posedge clk); #1;
            cycles++;
            if (disturb && cycles == 60) begin
                bus.start = 1'b1;
                bus.sum_x = ~sx;
                bus.sum_y = ~sy;
                bus.num   = n ^ {4{32'h0000_0007}};
            end
            if (disturb && cycles == 61) bus.start = 1'b0;
        end
        done_seen    = (bus.done === 1'b1);
        busy_at_done = bus.busy;
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic apply_reset();
        bus.start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.sum_x = '0;
        bus.sum_y = '0;
        bus.num   = '0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.avg_x !== '0 || bus.avg_y !== '0 || bus.zero_mask !== '0) begin
            failures++;
            $display("FAIL reset_results: avg_x=%0h avg_y=%0h zero_mask=%0b required all 0", bus.avg_x, bus.avg_y, bus.zero_mask);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%0b done=%0b div_start=%0b required 0 0 0", bus.busy, bus.done, bus.div_start);
        end
        checks++;
        if (bus.div_dividend !== '0 || bus.div_divisor !== '0) begin
            failures++;
            $display("FAIL reset_operands: dividend=%0h divisor=%0h required 0 0", bus.div_dividend, bus.div_divisor);
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%0b done=%0b required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_nominal();
        logic [4*SW-1:0] sx, sy, n;
        int ec, cyc;
        bit ds, bd, da, be;
        sx = pack4(1000, 2000, 4000, 8000);
        sy = pack4(500, 1000, 2000, 4000);
        n  = pack4(10, 20, 40, 80);
        div_lat = 33;
        model_run(sx, sy, n, ec);
        run(sx, sy, n, 1'b0, cyc, ds, bd, da, be);
        checks++;
        if (!ds || cyc != 290) begin
            failures++;
            $display("FAIL nominal_latency: done_seen=%0b cycles=%0d required 1 and 290", ds, cyc);
        end
        checks++;
        if (cyc != ec) begin
            failures++;
            $display("FAIL nominal_model_latency: cycles=%0d required %0d", cyc, ec);
        end
        checks++;
        if (bus.avg_x !== {4{10'd100}} || bus.avg_y !== {4{9'd50}}) begin
            failures++;
            $display("FAIL nominal_avg: avg_x=%0h avg_y=%0h required all 100 / all 50", bus.avg_x, bus.avg_y);
        end
        checks++;
        if (bus.avg_x !== pack_x() || bus.avg_y !== pack_y() || bus.zero_mask !== 4'b0000) begin
            failures++;
            $display("FAIL nominal_model: avg_x=%0h avg_y=%0h zm=%0b required %0h %0h 0000",
                     bus.avg_x, bus.avg_y, bus.zero_mask, pack_x(), pack_y());
        end
        checks++;
        if (start_count != 8) begin
            failures++;
            $display("FAIL nominal_div_starts: got %0d required 8", start_count);
        end
        checks++;
        if (bd !== 1'b0 || da !== 1'b0 || be !== 1'b1) begin
            failures++;
            $display("FAIL nominal_handshake: busy_at_done=%0b done_next=%0b busy_after_start=%0b required 0 0 1", bd, da, be);
        end
    endtask

    task automatic test_zero_color();
        logic [4*SW-1:0] sx, sy, n;
        int ec, cyc;
        bit ds, bd, da, be;
        sx = pack4(1000, 2000, 4000, 8000);
        sy = pack4(500, 1000, 2000, 4000);
        n  = pack4(10, 20, 0, 80);
        div_lat = 33;
        model_run(sx, sy, n, ec);
        run(sx, sy, n, 1'b0, cyc, ds, bd, da, be);
        checks++;
        if (bus.zero_mask !== 4'b0100) begin
            failures++;
            $display("FAIL zero_mask: got %0b required 0100", bus.zero_mask);
        end
        checks++;
        if (start_count != 6) begin
            failures++;
            $display("FAIL zero_div_starts: got %0d required 6", start_count);
        end
        checks++;
        if (bus.avg_x !== pack_x() || bus.avg_y !== pack_y()) begin
            failures++;
            $display("FAIL zero_hold: avg_x=%0h avg_y=%0h required %0h %0h", bus.avg_x, bus.avg_y, pack_x(), pack_y());
        end
        checks++;
        if (!ds || cyc != ec) begin
            failures++;
            $display("FAIL zero_latency: done_seen=%0b cycles=%0d required 1 and %0d", ds, cyc, ec);
        end
    endtask

    task automatic test_saturation();
        logic [4*SW-1:0] sx, sy, n;
        int ec, cyc;
        bit ds, bd, da, be;
        sx = pack4(5000, 2000, 4000, 8000);
        sy = pack4(600, 1000, 2000, 4000);
        n  = pack4(1, 20, 40, 80);
        div_lat = 5;
        model_run(sx, sy, n, ec);
        run(sx, sy, n, 1'b0, cyc, ds, bd, da, be);
        checks++;
        if (bus.avg_x !== pack_x() || bus.avg_y !== pack_y()) begin
            failures++;
            $display("FAIL sat_model: avg_x=%0h avg_y=%0h required %0h %0h", bus.avg_x, bus.avg_y, pack_x(), pack_y());
        end
`ifndef DIV_SCHED_SMOOTH_EN
        checks++;
        if (bus.avg_x[9:0] !== 10'd1023 || bus.avg_y[8:0] !== 9'd511) begin
            failures++;
            $display("FAIL sat_field0: x0=%0d y0=%0d required 1023 511", bus.avg_x[9:0], bus.avg_y[8:0]);
        end
`endif
    endtask

    task automatic test_ignore_start();
        logic [4*SW-1:0] sx, sy, n;
        int ec, cyc;
        bit ds, bd, da, be;
        sx = pack4(3000, 999, 12345, 700);
        sy = pack4(300, 4000, 2222, 1800);
        n  = pack4(7, 13, 25, 3);
        div_lat = 33;
        model_run(sx, sy, n, ec);
        run(sx, sy, n, 1'b1, cyc, ds, bd, da, be);
        checks++;
        if (bus.avg_x !== pack_x() || bus.avg_y !== pack_y() || bus.zero_mask !== exp_zm) begin
            failures++;
            $display("FAIL ignore_start_results: avg_x=%0h avg_y=%0h zm=%0b required %0h %0h %0b",
                     bus.avg_x, bus.avg_y, bus.zero_mask, pack_x(), pack_y(), exp_zm);
        end
        checks++;
        if (!ds || cyc != ec || start_count != 8) begin
            failures++;
            $display("FAIL ignore_start_timing: done_seen=%0b cycles=%0d starts=%0d required 1 %0d 8", ds, cyc, start_count, ec);
        end
    endtask

    task automatic test_reset_mid();
        logic [4*SW-1:0] sx, sy, n;
        int ec, cyc, cnt, done_cnt, busy_cnt;
        bit ds, bd, da, be;
        sx = pack4(1000, 2000, 4000, 8000);
        sy = pack4(500, 1000, 2000, 4000);
        n  = pack4(10, 20, 40, 80);
        div_lat     = 33;
        bus.sum_x   = sx;
        bus.sum_y   = sy;
        bus.num     = n;
        start_count = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        while (start_count < 5 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (start_count != 5) begin
            failures++;
            $display("FAIL reach_job4: div_starts=%0d required 5", start_count);
        end
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.avg_x !== '0 || bus.avg_y !== '0 || bus.zero_mask !== '0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.div_start !== 1'b0 || bus.div_dividend !== '0 || bus.div_divisor !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: avg_x=%0h avg_y=%0h zm=%0b busy=%0b done=%0b ds=%0b dd=%0h dv=%0h required all 0",
                     bus.avg_x, bus.avg_y, bus.zero_mask, bus.busy, bus.done, bus.div_start, bus.div_dividend, bus.div_divisor);
        end
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        reset    = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            failures++;
            $display("FAIL midreset_quiet: done_cycles=%0d busy_cycles=%0d required 0 0", done_cnt, busy_cnt);
        end
        model_run(sx, sy, n, ec);
        run(sx, sy, n, 1'b0, cyc, ds, bd, da, be);
        checks++;
        if (!ds || cyc != ec || bus.avg_x !== pack_x() || bus.avg_y !== pack_y()) begin
            failures++;
            $display("FAIL midreset_rerun: done_seen=%0b cycles=%0d avg_x=%0h avg_y=%0h required 1 %0d %0h %0h",
                     ds, cyc, bus.avg_x, bus.avg_y, ec, pack_x(), pack_y());
        end
    endtask

    task automatic test_random();
        logic [4*SW-1:0] sx, sy, n;
        int ec, cyc;
        bit ds, bd, da, be;
        for (int it = 0; it < 12; it++) begin
            div_lat = $urandom_range(2, 12);
            for (int c = 0; c < 4; c++) begin
                sx[c*SW +: SW] = $urandom_range(0, 3000000);
                sy[c*SW +: SW] = $urandom_range(0, 3000000);
                n[c*SW +: SW]  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 3000));
            end
            model_run(sx, sy, n, ec);
            run(sx, sy, n, 1'b0, cyc, ds, bd, da, be);
            checks++;
            if (!ds || cyc != ec) begin
                failures++;
                $display("FAIL rand_latency[%0d]: done_seen=%0b cycles=%0d required 1 %0d", it, ds, cyc, ec);
            end
            checks++;
            if (bus.avg_x !== pack_x() || bus.avg_y !== pack_y() || bus.zero_mask !== exp_zm) begin
                failures++;
                $display("FAIL rand_results[%0d]: avg_x=%0h avg_y=%0h zm=%0b required %0h %0h %0b",
                         it, bus.avg_x, bus.avg_y, bus.zero_mask, pack_x(), pack_y(), exp_zm);
            end
        end
    endtask

`ifdef DIV_SCHED_SMOOTH_EN
    task automatic test_smooth();
        logic [4*SW-1:0] sx, sy, n;
        int ec, cyc;
        bit ds, bd, da, be;
        apply_reset();
        div_lat = 4;
        sx = pack4(400, 2000, 4000, 8000);
        sy = pack4(500, 1000, 2000, 4000);
        n  = pack4(1, 20, 40, 80);
        model_run(sx, sy, n, ec);
        run(sx, sy, n, 1'b0, cyc, ds, bd, da, be);
        checks++;
        if (bus.avg_x[9:0] !== 10'd200) begin
            failures++;
            $display("FAIL smooth_first: x0=%0d required 200", bus.avg_x[9:0]);
        end
        sx = pack4(100, 2000, 4000, 8000);
        model_run(sx, sy, n, ec);
        run(sx, sy, n, 1'b0, cyc, ds, bd, da, be);
        checks++;
        if (bus.avg_x[9:0] !== 10'd150 || bus.avg_x !== pack_x() || bus.avg_y !== pack_y()) begin
            failures++;
            $display("FAIL smooth_blend: x0=%0d avg_x=%0h avg_y=%0h required 150 %0h %0h",
                     bus.avg_x[9:0], bus.avg_x, bus.avg_y, pack_x(), pack_y());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_zero_color();
        test_saturation();
        test_ignore_start();
        test_reset_mid();
        test_random();
`ifdef DIV_SCHED_SMOOTH_EN
        test_smooth();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
